// File: rtl/fir_pkg.sv
// Shared constants, types and helpers for the FIR output capture block.
package fir_pkg;

    localparam int OUT_MAX = 32767;
    localparam int OUT_MIN = -32768;

    localparam logic [3:0] KEEP_ALL = 4'hF;

    typedef enum logic {
        CAP_IDLE   = 1'b0,
        CAP_ACTIVE = 1'b1
    } cap_state_e;

    // Half an LSB of the retained result, added before the arithmetic shift.
    function automatic longint round_offset(input int shift);
        return (shift > 0) ? (64'sd1 <<< (shift - 1)) : 64'sd0;
    endfunction

endpackage

// File: rtl/fir_axis_capture_if.sv
// AXI-Stream bundle used for both the FIR input stream and the rounded output stream.
interface fir_axis_capture_if #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = 4
);
    // A beat transfers on a rising clk edge where tvalid && tready are both high;
    // the master holds tdata/tkeep/tlast stable while tvalid is high and tready is low.
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, tkeep, tlast, tvalid, input  tready);
    modport slave  (input  tdata, tkeep, tlast, tvalid, output tready);

endinterface

// File: rtl/fir_sync_fifo.sv
// Single-clock FIFO holding {tlast, sample} words; read data is forced to zero while empty.
module fir_sync_fifo #(
    parameter  int W     = 17,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  wr_data,
    input  logic          pop,
    output logic [W-1:0]  rd_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fir_axis_capture.sv
// Receives 32-bit FIR products, rounds/saturates them to 16 bits, buffers them and
// re-emits them on a 16-bit stream while tracking per-frame statistics.
module fir_axis_capture
    import fir_pkg::*;
#(
    parameter int IN_W      = 32,
    parameter int OUT_W     = 16,
    parameter int SHIFT     = 15,
    parameter int DEPTH     = 8,
    parameter int FRAME_LEN = 32
) (
    input  logic               clk,
    input  logic               reset,
    fir_axis_capture_if.slave  s_axis_fir,
    fir_axis_capture_if.master m_axis,
    output logic               frame_done,
    output logic               keep_err,
    output logic [15:0]        sample_cnt,
    output logic [OUT_W-1:0]   peak_abs,
    output logic [7:0]         sat_cnt,
    output cap_state_e         dbg_state
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = $clog2(FRAME_LEN + 1);
    localparam logic signed [IN_W:0] RND   = (IN_W+1)'(round_offset(SHIFT));
    localparam logic signed [IN_W:0] R_MAX = (IN_W+1)'(OUT_MAX);
    localparam logic signed [IN_W:0] R_MIN = (IN_W+1)'(OUT_MIN);

    function automatic logic [OUT_W-1:0] abs_sat(input logic [OUT_W-1:0] x);
        if (x == {1'b1, {(OUT_W-1){1'b0}}}) return {1'b0, {(OUT_W-1){1'b1}}};
        return x[OUT_W-1] ? -x : x;
    endfunction

    logic [CW-1:0]        fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW:0]          occupancy;
    logic                 accept;
    logic                 keep_ok;
    logic signed [IN_W:0] in_ext;
    logic signed [IN_W:0] r_full;
    logic                 sat_hi;
    logic                 sat_lo;
    logic [OUT_W-1:0]     rnd_data;
    logic                 pipe_valid;
    logic [OUT_W-1:0]     pipe_data;
    logic                 pipe_last;
    logic                 pipe_sat;
    logic [FW-1:0]        frame_idx;
    logic                 word_last;
    logic [OUT_W-1:0]     peak_run;
    logic [OUT_W-1:0]     sample_abs;
    logic [OUT_W-1:0]     peak_cand;
    logic                 close_frame;
    cap_state_e           state;
    cap_state_e           state_nxt;

    // Counting the pipeline slot keeps an in-flight beat from overrunning a full FIFO.
    assign occupancy         = {1'b0, fifo_count} + {{CW{1'b0}}, pipe_valid};
    assign s_axis_fir.tready = !fifo_full && (occupancy < (CW+1)'(DEPTH));
    assign accept            = s_axis_fir.tvalid && s_axis_fir.tready;
    assign keep_ok           = (s_axis_fir.tkeep == KEEP_ALL);

    always_comb begin
        in_ext   = {s_axis_fir.tdata[IN_W-1], s_axis_fir.tdata};
        r_full   = (in_ext + RND) >>> SHIFT;
        sat_hi   = (r_full > R_MAX);
        sat_lo   = (r_full < R_MIN);
        rnd_data = r_full[OUT_W-1:0];
        if (sat_hi)      rnd_data = OUT_W'(OUT_MAX);
        else if (sat_lo) rnd_data = OUT_W'(OUT_MIN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_valid <= 1'b0;
            pipe_data  <= '0;
            pipe_last  <= 1'b0;
            pipe_sat   <= 1'b0;
            keep_err   <= 1'b0;
        end else begin
            pipe_valid <= accept && keep_ok;
            keep_err   <= accept && !keep_ok;
            if (accept && keep_ok) begin
                pipe_data <= rnd_data;
                pipe_last <= s_axis_fir.tlast;
                pipe_sat  <= sat_hi || sat_lo;
            end
        end
    end

    assign word_last = pipe_last || (frame_idx == FW'(FRAME_LEN - 1));

    fir_sync_fifo #(.W(OUT_W + 1), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (pipe_valid),
        .wr_data ({word_last, pipe_data}),
        .pop     (m_axis.tvalid && m_axis.tready),
        .rd_data ({m_axis.tlast, m_axis.tdata}),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_axis.tvalid = !fifo_empty;
    assign m_axis.tkeep  = '1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= CAP_IDLE;
        else        state <= state_nxt;
    end

    // A one-word frame opens and closes on the same write, so IDLE stays IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            CAP_IDLE:   if (pipe_valid && !word_last) state_nxt = CAP_ACTIVE;
            CAP_ACTIVE: if (pipe_valid && word_last)  state_nxt = CAP_IDLE;
            default:    state_nxt = CAP_IDLE;
        endcase
    end

    always_comb begin
        close_frame = 1'b0;
        case (state)
            CAP_IDLE:   close_frame = pipe_valid && word_last;
            CAP_ACTIVE: close_frame = pipe_valid && word_last;
            default:    close_frame = 1'b0;
        endcase
    end

    assign dbg_state  = state;
    assign sample_abs = abs_sat(pipe_data);
    assign peak_cand  = (sample_abs > peak_run) ? sample_abs : peak_run;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_done <= 1'b0;
            sample_cnt <= '0;
            sat_cnt    <= '0;
            peak_abs   <= '0;
            peak_run   <= '0;
            frame_idx  <= '0;
        end else begin
            frame_done <= close_frame;
            if (pipe_valid) begin
                sample_cnt <= sample_cnt + 1'b1;
                if (pipe_sat && sat_cnt != 8'hFF) sat_cnt <= sat_cnt + 1'b1;
                if (close_frame) begin
                    peak_abs  <= peak_cand;
                    peak_run  <= '0;
                    frame_idx <= '0;
                end else begin
                    peak_run  <= peak_cand;
                    frame_idx <= frame_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_axis_capture.sv
// Bench for fir_axis_capture: directed and random beats scored against an arithmetic model.
module tb_fir_axis_capture;
    import fir_pkg::*;

    localparam int FRAME_LEN = 32;
    localparam int DEPTH     = 8;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        frame_done;
    logic        keep_err;
    logic [15:0] sample_cnt;
    logic [15:0] peak_abs;
    logic [7:0]  sat_cnt;
    cap_state_e  dbg_state;

    fir_axis_capture_if #(.DATA_W(32), .KEEP_W(4)) s_if ();
    fir_axis_capture_if #(.DATA_W(16), .KEEP_W(2)) m_if ();

    fir_axis_capture #(
        .IN_W(32), .OUT_W(16), .SHIFT(15), .DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_axis_fir (s_if),
        .m_axis     (m_if),
        .frame_done (frame_done),
        .keep_err   (keep_err),
        .sample_cnt (sample_cnt),
        .peak_abs   (peak_abs),
        .sat_cnt    (sat_cnt),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard state ----------------
    logic [16:0] exp_q[$];
    int n_checks = 0;
    int n_errs   = 0;
    int fd_cnt   = 0;
    int kerr_cnt = 0;
    int fd_base  = 0;
    int kerr_base = 0;
    bit rand_rdy = 0;

    int mdl_samples, mdl_sat, mdl_idx, mdl_run, mdl_peak, mdl_frames, mdl_kerr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: round half up at bit 15, clamp to int16, frame every 32 words or on tlast.
    task automatic model_accept(input logic [31:0] d, input logic [3:0] k, input logic l);
        longint r;
        bit     sat;
        bit     lst;
        int     a;
        if (k != 4'hF) begin
            mdl_kerr++;
            return;
        end
        r   = (longint'($signed(d)) + 64'sd16384) >>> 15;
        sat = 0;
        if (r > 32767)       begin r = 32767;  sat = 1; end
        else if (r < -32768) begin r = -32768; sat = 1; end
        lst = l || (mdl_idx == FRAME_LEN - 1);
        exp_q.push_back({lst, 16'(r)});
        mdl_samples++;
        if (sat && mdl_sat < 255) mdl_sat++;
        a = (r < 0) ? int'(-r) : int'(r);
        if (a > 32767) a = 32767;
        if (a > mdl_run) mdl_run = a;
        if (lst) begin
            mdl_peak = mdl_run;
            mdl_run  = 0;
            mdl_idx  = 0;
            mdl_frames++;
        end else begin
            mdl_idx++;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [16:0] e;
        if (reset) begin
            if (frame_done) fd_cnt++;
            if (keep_err)   kerr_cnt++;
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    check("out_extra", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 32'(m_if.tdata), 32'(e[15:0]));
                    check("out_last", 32'(m_if.tlast), 32'(e[16]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        bit rdy;
        int tries;
        tries = 0;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        do begin
            if (rand_rdy) m_if.tready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            rdy = s_if.tready;
            tick();
            tries++;
        end while (!rdy && tries < 100);
        s_if.tvalid = 1'b0;
        check("send_accept", 32'(rdy), 32'd1);
        if (rdy) model_accept(d, k, l);
    endtask

    task automatic drain();
        int n;
        n = 0;
        rand_rdy     = 0;
        m_if.tready  = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();
    endtask

    task automatic do_reset();
        s_if.tvalid = 1'b0;
        reset       = 1'b0;
        #1;
        check("rst_s_tready",  32'(s_if.tready),  32'd1);
        check("rst_m_tvalid",  32'(m_if.tvalid),  32'd0);
        check("rst_m_tdata",   32'(m_if.tdata),   32'd0);
        check("rst_m_tlast",   32'(m_if.tlast),   32'd0);
        check("rst_frame_done", 32'(frame_done),  32'd0);
        check("rst_keep_err",  32'(keep_err),     32'd0);
        check("rst_sample_cnt", 32'(sample_cnt),  32'd0);
        check("rst_peak_abs",  32'(peak_abs),     32'd0);
        check("rst_sat_cnt",   32'(sat_cnt),      32'd0);
        check("rst_state",     32'(dbg_state),    32'd0);
        exp_q.delete();
        mdl_samples = 0; mdl_sat = 0; mdl_idx = 0; mdl_run = 0;
        mdl_peak = 0; mdl_frames = 0; mdl_kerr = 0;
        fd_base   = fd_cnt;
        kerr_base = kerr_cnt;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_sample_cnt"}, 32'(sample_cnt), 32'(16'(mdl_samples)));
        check({tag, "_sat_cnt"},    32'(sat_cnt),    32'(mdl_sat));
        check({tag, "_peak_abs"},   32'(peak_abs),   32'(mdl_peak));
        check({tag, "_frames"},     32'(fd_cnt - fd_base),     32'(mdl_frames));
        check({tag, "_keep_errs"},  32'(kerr_cnt - kerr_base), 32'(mdl_kerr));
    endtask

    function automatic logic [31:0] rand_sample();
        case ($urandom_range(0, 3))
            0:       return $urandom();
            1:       return 32'($signed($urandom_range(0, 131072)) - 65536);
            2:       return ($urandom_range(0, 1) != 0) ? 32'h3FFF_0000 + $urandom_range(0, 65535)
                                                        : 32'hC000_0000 - $urandom_range(0, 65535);
            default: return 32'($signed($urandom_range(0, 2147483647)) >>> $urandom_range(0, 16));
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] bp_data [10];
        int          idx;
        int          c0;
        bit          rdy;

        s_if.tdata = '0; s_if.tkeep = 4'hF; s_if.tlast = 1'b0; s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        #2;
        do_reset();

        // Rounding corners, then values straddling the saturation thresholds.
        send_beat(32'h0000_4000, 4'hF, 1'b0);
        send_beat(32'hFFFF_C000, 4'hF, 1'b0);
        send_beat(32'h0000_3FFF, 4'hF, 1'b0);
        send_beat(32'hFFFF_8000, 4'hF, 1'b0);
        drain();
        check("round_sat_cnt", 32'(sat_cnt), 32'(mdl_sat));
        send_beat(32'h3FFF_8000, 4'hF, 1'b0);
        send_beat(32'hC000_0000, 4'hF, 1'b0);
        send_beat(32'h4000_0000, 4'hF, 1'b0);
        send_beat(32'hBFFF_0000, 4'hF, 1'b0);
        drain();
        check("sat_cnt_two", 32'(sat_cnt), 32'(mdl_sat));
        for (int i = 0; i < 300; i++)
            send_beat((i % 2 == 0) ? 32'h7FFF_0000 : 32'h8000_0000, 4'hF, 1'b0);
        drain();
        check("sat_cnt_sticky", 32'(sat_cnt), 32'(mdl_sat));
        check_stats("sat");

        // Backpressure: output stalled, ten beats offered.
        do_reset();
        m_if.tready = 1'b0;
        for (int i = 0; i < 10; i++) bp_data[i] = rand_sample();
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            s_if.tdata = bp_data[idx]; s_if.tkeep = 4'hF; s_if.tlast = 1'b0;
            s_if.tvalid = (idx < 10);
            @(negedge clk);
            rdy = s_if.tready && s_if.tvalid;
            tick();
            if (rdy) begin
                model_accept(bp_data[idx], 4'hF, 1'b0);
                idx++;
            end
        end
        s_if.tvalid = 1'b0;
        check("bp_accepted", 32'(idx), 32'd8);
        @(negedge clk);
        check("bp_tready_low", 32'(s_if.tready), 32'd0);
        check("bp_hold_data0", 32'(m_if.tdata), 32'(exp_q[0][15:0]));
        repeat (3) @(negedge clk);
        check("bp_hold_data1", 32'(m_if.tdata), 32'(exp_q[0][15:0]));
        check("bp_hold_last",  32'(m_if.tlast), 32'(exp_q[0][16]));
        tick();
        m_if.tready = 1'b1;
        @(negedge clk);
        check("bp_full_at_pop", 32'(s_if.tready), 32'd0);
        @(negedge clk);
        check("bp_rise_after_pop", 32'(s_if.tready), 32'd1);
        tick();
        drain();

        // Framing: a full-length frame at line rate, then a short tlast frame.
        do_reset();
        c0 = cyc;
        for (int i = 0; i < FRAME_LEN; i++) send_beat(rand_sample(), 4'hF, 1'b0);
        check("throughput_cycles", 32'(cyc - c0), 32'(FRAME_LEN));
        drain();
        check("frame_len_done", 32'(fd_cnt - fd_base), 32'd1);
        for (int i = 0; i < 3; i++) send_beat(rand_sample(), 4'hF, 1'b0);
        drain();
        check("frame_state_mid", 32'(dbg_state), 32'((mdl_idx != 0) ? 1 : 0));
        send_beat(rand_sample(), 4'hF, 1'b0);
        send_beat(32'hF000_0000 + $urandom_range(0, 65535), 4'hF, 1'b1);
        drain();
        check("frame_short_done", 32'(fd_cnt - fd_base), 32'd2);
        check("frame_state_end", 32'(dbg_state), 32'd0);
        check_stats("frame");

        // Partial tkeep beat is swallowed.
        send_beat(32'h0012_3456, 4'h3, 1'b0);
        repeat (3) tick();
        check("keep_err_pulses", 32'(kerr_cnt - kerr_base), 32'd1);
        check("keep_no_output", 32'(m_if.tvalid), 32'd0);
        check_stats("keep");

        // Random traffic with random downstream stalls.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rand_rdy = 1;
            send_beat(rand_sample(),
                      ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'hF,
                      ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 7) == 0) tick();
        end
        drain();
        check_stats("rand");

        // Reset with words buffered, then first-word latency.
        m_if.tready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(rand_sample(), 4'hF, 1'b0);
        repeat (2) tick();
        do_reset();
        m_if.tready = 1'b1;
        send_beat(32'h0001_4000, 4'hF, 1'b0);
        @(negedge clk);
        check("lat_not_yet", 32'(m_if.tvalid), 32'd0);
        @(negedge clk);
        check("lat_two_cycles", 32'(m_if.tvalid), 32'd1);
        tick();
        drain();
        check_stats("post_rst");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
